// File: rtl/wide_adder_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fast_adder
// Description : BITS-wide parallel-prefix (Kogge-Stone) carry-lookahead adder
//               chunk. Besides the sum it exports the block generate and block
//               propagate terms so a caller can chain several chunks through a
//               registered carry without waiting on an internal carry-out.
// Ports       : a_in, b_in   operand chunks
//               c_in         carry into bit 0
//               sum_out      a_in + b_in + c_in (modulo 2^BITS)
//               gg_out       block generate  (carry out regardless of c_in)
//               pg_out       block propagate (carry out equals c_in)
// Revision    : 1.0 - initial release
// ============================================================================
module fast_adder #(
    parameter int BITS = 16
) (
    input  logic [BITS-1:0] a_in,
    input  logic [BITS-1:0] b_in,
    input  logic            c_in,
    output logic [BITS-1:0] sum_out,
    output logic            gg_out,
    output logic            pg_out
);

    logic [BITS-1:0] w_half;     // per-bit propagate (a ^ b), also the sum seed
    logic [BITS-1:0] w_gen;      // prefix generate over bits [i:0]
    logic [BITS-1:0] w_prop;     // prefix propagate over bits [i:0]
    logic [BITS-1:0] w_gen_nx;
    logic [BITS-1:0] w_prop_nx;
    logic [BITS-1:0] w_carry;    // carry into each bit position

    // Prefix tree: each pass doubles the span that every position summarises,
    // so after ceil(log2(BITS)) passes position i covers bits i down to 0.
    always_comb begin
        w_half    = a_in ^ b_in;
        w_gen     = a_in & b_in;
        w_prop    = w_half;
        w_gen_nx  = w_gen;
        w_prop_nx = w_prop;
        for (int d = 1; d < BITS; d = d * 2) begin
            w_gen_nx  = w_gen;
            w_prop_nx = w_prop;
            for (int i = d; i < BITS; i++) begin
                w_gen_nx[i]  = w_gen[i] | (w_prop[i] & w_gen[i-d]);
                w_prop_nx[i] = w_prop[i] & w_prop[i-d];
            end
            w_gen  = w_gen_nx;
            w_prop = w_prop_nx;
        end
    end

    // Every bit's carry is resolved directly from its prefix terms and c_in,
    // so there is no ripple path through the chunk.
    always_comb begin
        w_carry    = '0;
        w_carry[0] = c_in;
        for (int i = 1; i < BITS; i++) begin
            w_carry[i] = w_gen[i-1] | (w_prop[i-1] & c_in);
        end
    end

    assign sum_out = w_half ^ w_carry;
    assign gg_out  = w_gen[BITS-1];
    assign pg_out  = w_prop[BITS-1];

endmodule

// ============================================================================
// Module      : wide_adder_sequencer
// Description : Computes a WORDS*BITS-bit add or subtract by stepping one
//               shared BITS-wide fast_adder over the operand chunks, least
//               significant chunk first, one chunk per clock. The inter-chunk
//               carry lives in a register. Valid/ready handshakes on both the
//               request and the response side; one operation in flight.
// Parameters  : BITS   width of the shared adder (one chunk)
//               WORDS  chunks per operation, must be >= 1
// Ports       : clk_in         clock, rising edge
//               reset_in       synchronous active-high reset
//               req_valid_in   request operands valid
//               req_ready_out  sequencer idle and able to accept
//               a_in, b_in     WORDS*BITS-bit operands
//               c_in           carry-in (add) / borrow-in (subtract)
//               sub_in         0: A+B+c   1: A-B-c
//               rsp_valid_out  result valid, held until accepted
//               rsp_ready_in   consumer accepts the result
//               sum_out        result (modulo 2^(WORDS*BITS))
//               carry_out      final carry; for subtract 1 means no borrow
//               zero_out       sum_out == 0
// Revision    : 1.0 - initial release
// ============================================================================
module wide_adder_sequencer #(
    parameter int BITS  = 16,
    parameter int WORDS = 2
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic [WORDS*BITS-1:0] a_in,
    input  logic [WORDS*BITS-1:0] b_in,
    input  logic                  c_in,
    input  logic                  sub_in,
    output logic                  rsp_valid_out,
    input  logic                  rsp_ready_in,
    output logic [WORDS*BITS-1:0] sum_out,
    output logic                  carry_out,
    output logic                  zero_out
);

    // A one-chunk operation still needs a one-bit index register.
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [IDX_W-1:0]           r_idx;
    logic [WORDS-1:0][BITS-1:0] r_a;
    logic [WORDS-1:0][BITS-1:0] r_b;        // already inverted for subtract
    logic [WORDS-1:0][BITS-1:0] r_result;
    logic                       r_carry;    // carry into the next chunk / final carry

    logic                       w_accept;
    logic                       w_step;
    logic                       w_last;
    logic [BITS-1:0]            w_a_chunk;
    logic [BITS-1:0]            w_b_chunk;
    logic [BITS-1:0]            w_sum;
    logic                       w_gg;
    logic                       w_pg;

    assign w_last = (r_idx == IDX_W'(WORDS - 1));

    // ------------------------------------------------------------------
    // Control: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Control: next state and handshake outputs. A request seen while in
    // DONE (even on the handshake edge) is left pending; it can only be
    // taken once the sequencer is back in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_step        = 1'b0;
        req_ready_out = 1'b0;
        rsp_valid_out = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready_out = 1'b1;
                if (req_valid_in) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid_out = 1'b1;
                if (rsp_ready_in) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Chunk select feeding the shared adder
    // ------------------------------------------------------------------
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_chunk = r_a[i];
                w_b_chunk = r_b[i];
            end
        end
    end

    fast_adder #(
        .BITS    (BITS)
    ) u_adder (
        .a_in    (w_a_chunk),
        .b_in    (w_b_chunk),
        .c_in    (r_carry),
        .sum_out (w_sum),
        .gg_out  (w_gg),
        .pg_out  (w_pg)
    );

    // ------------------------------------------------------------------
    // Datapath. Subtract is A + ~B + 1 - c, so the inverted B is latched
    // and the initial carry becomes c ^ sub. Operand inputs are looked at
    // only on the accepting edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a_in;
            r_b     <= sub_in ? ~b_in : b_in;
            r_carry <= c_in ^ sub_in;
            r_idx   <= '0;
        end else if (w_step) begin
            for (int i = 0; i < WORDS; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    r_result[i] <= w_sum;
                end
            end
            r_carry <= w_gg | (w_pg & r_carry);
            // Parks on the last chunk; the next accept clears it.
            if (!w_last) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // The result register is kept after the handshake, so sum_out keeps
    // showing the last result while idle.
    assign sum_out   = r_result;
    assign carry_out = r_carry;
    assign zero_out  = (r_result == '0);

endmodule
`default_nettype wire

// File: tb/tb_wide_adder_sequencer.sv
`default_nettype none
module tb_wide_adder_sequencer;

    localparam int BITS  = 16;
    localparam int WORDS = 2;
    localparam int W     = BITS * WORDS;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    // main instance (WORDS = 2)
    logic          clk_in       = 1'b0;
    logic          reset_in     = 1'b1;
    logic          req_valid_in = 1'b0;
    logic          req_ready_out;
    logic [W-1:0]  a_in         = '0;
    logic [W-1:0]  b_in         = '0;
    logic          c_in         = 1'b0;
    logic          sub_in       = 1'b0;
    logic          rsp_valid_out;
    logic          rsp_ready_in = 1'b0;
    logic [W-1:0]  sum_out;
    logic          carry_out;
    logic          zero_out;

    // single-chunk instance (WORDS = 1)
    logic             w1_req_valid = 1'b0;
    logic             w1_req_ready;
    logic [BITS-1:0]  w1_a         = '0;
    logic [BITS-1:0]  w1_b         = '0;
    logic             w1_c         = 1'b0;
    logic             w1_sub       = 1'b0;
    logic             w1_rsp_valid;
    logic             w1_rsp_ready = 1'b0;
    logic [BITS-1:0]  w1_sum;
    logic             w1_carry;
    logic             w1_zero;

    int n_cmp  = 0;
    int n_bad  = 0;
    bit chk_en = 1'b0;

    wide_adder_sequencer #(.BITS(BITS), .WORDS(WORDS)) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .req_valid_in  (req_valid_in),
        .req_ready_out (req_ready_out),
        .a_in          (a_in),
        .b_in          (b_in),
        .c_in          (c_in),
        .sub_in        (sub_in),
        .rsp_valid_out (rsp_valid_out),
        .rsp_ready_in  (rsp_ready_in),
        .sum_out       (sum_out),
        .carry_out     (carry_out),
        .zero_out      (zero_out)
    );

    wide_adder_sequencer #(.BITS(BITS), .WORDS(1)) dut1 (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .req_valid_in  (w1_req_valid),
        .req_ready_out (w1_req_ready),
        .a_in          (w1_a),
        .b_in          (w1_b),
        .c_in          (w1_c),
        .sub_in        (w1_sub),
        .rsp_valid_out (w1_rsp_valid),
        .rsp_ready_in  (w1_rsp_ready),
        .sum_out       (w1_sum),
        .carry_out     (w1_carry),
        .zero_out      (w1_zero)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic on w-bit unsigned values: bit 64 = carry / no-borrow.
    function automatic logic [64:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                           input logic c, input logic s, input int w);
        logic [63:0] mask;
        logic [64:0] full;
        logic [64:0] r;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        if (!s) begin
            full = {1'b0, a} + {1'b0, b} + {64'd0, c};
            r    = {full[w], full[63:0] & mask};
        end else begin
            r = {({1'b0, a} >= ({1'b0, b} + {64'd0, c})), (a - b - {63'd0, c}) & mask};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model of the main instance: one job in flight, result
    // appears WORDS clocks after acceptance and waits for the consumer.
    // ------------------------------------------------------------------
    int           m_ph = M_IDLE;
    int           m_cnt = 0;
    logic [W-1:0] m_sum = '0;
    logic [W-1:0] m_psum = '0;
    logic         m_carry = 1'b0;
    logic         m_pcarry = 1'b0;
    bit           m_fresh = 1'b1;
    logic [64:0]  m_req_res;

    assign m_req_res = ref_op(64'(a_in), 64'(b_in), c_in, sub_in, W);

    always @(posedge clk_in) begin
        if (reset_in) begin
            m_ph    <= M_IDLE;
            m_sum   <= '0;
            m_carry <= 1'b0;
            m_fresh <= 1'b1;
        end else begin
            case (m_ph)
                M_IDLE: if (req_valid_in) begin
                    m_psum   <= m_req_res[W-1:0];
                    m_pcarry <= m_req_res[64];
                    m_cnt    <= WORDS;
                    m_ph     <= M_RUN;
                    m_fresh  <= 1'b0;
                end
                M_RUN: begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) begin
                        m_ph    <= M_DONE;
                        m_sum   <= m_psum;
                        m_carry <= m_pcarry;
                    end
                end
                M_DONE: if (rsp_ready_in) m_ph <= M_IDLE;
                default: m_ph <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("req_ready", req_ready_out, m_ph == M_IDLE);
            chk("rsp_valid", rsp_valid_out, m_ph == M_DONE);
            if (m_ph != M_RUN) begin
                chk("sum", sum_out, m_sum);
                chk("zero", zero_out, m_sum == '0);
            end
            if (m_ph == M_DONE || m_fresh) begin
                chk("carry", carry_out, (m_ph == M_DONE) ? m_carry : 1'b0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers (start and end 2 time units after a rising edge)
    // ------------------------------------------------------------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, output int t);
        logic rdy;
        t            = 0;
        req_valid_in = 1'b1;
        a_in = a; b_in = b; c_in = c; sub_in = s;
        do begin
            @(negedge clk_in);
            rdy = req_ready_out;
            @(posedge clk_in);
            #2;
            t++;
        end while (!rdy && t < 100);
        if (!rdy) chk("accept_timeout", 1'b0, 1'b1);
        req_valid_in = 1'b0;
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        c_in   = 1'($urandom_range(0, 1));
        sub_in = 1'($urandom_range(0, 1));
    endtask

    task automatic recv(input int hold, input bit pre, input bit lit,
                        input logic [W-1:0] es, input logic ec);
        int k = 0;
        if (pre) rsp_ready_in = 1'b1;
        do begin
            @(negedge clk_in);
            k++;
        end while (!rsp_valid_out && k < 50);
        chk("latency", 65'(k - 1), 65'(WORDS));
        if (!rsp_valid_out) begin
            rsp_ready_in = 1'b0;
            return;
        end
        if (lit) begin
            chk("lit_sum", sum_out, es);
            chk("lit_carry", carry_out, ec);
            chk("lit_zero", zero_out, es == '0);
        end
        if (!pre) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk_in);
                if (lit) chk("hold_sum", sum_out, es);
                chk("hold_ready", req_ready_out, 1'b0);
            end
            #1 rsp_ready_in = 1'b1;
        end
        @(posedge clk_in);
        #2 rsp_ready_in = 1'b0;
    endtask

    task automatic op1(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                       input logic c, input logic s);
        logic [64:0] e;
        int k = 0;
        e = ref_op(64'(a), 64'(b), c, s, BITS);
        w1_req_valid = 1'b1;
        w1_a = a; w1_b = b; w1_c = c; w1_sub = s;
        @(negedge clk_in);
        chk("w1_ready", w1_req_ready, 1'b1);
        @(posedge clk_in);
        #2;
        w1_req_valid = 1'b0;
        w1_a = BITS'($urandom);
        w1_b = BITS'($urandom);
        do begin
            @(negedge clk_in);
            k++;
        end while (!w1_rsp_valid && k < 20);
        chk("w1_latency", 65'(k - 1), 65'd1);
        chk("w1_sum", w1_sum, e[BITS-1:0]);
        chk("w1_carry", w1_carry, e[64]);
        chk("w1_zero", w1_zero, e[BITS-1:0] == '0);
        #1 w1_rsp_ready = 1'b1;
        @(posedge clk_in);
        #2 w1_rsp_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete, got timeout required finish");
        $fatal(1);
    end

    initial begin
        int t;
        logic [W-1:0] ra, rb;
        logic rc, rs;
        int sel;

        // reset for three edges
        @(posedge clk_in);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk_in);
        #2 reset_in = 1'b0;
        @(negedge clk_in);
        chk("rst_ready", req_ready_out, 1'b1);
        chk("rst_valid", rsp_valid_out, 1'b0);
        chk("rst_sum", sum_out, '0);
        chk("rst_carry", carry_out, 1'b0);
        chk("rst_zero", zero_out, 1'b1);
        chk("w1_rst_valid", w1_rsp_valid, 1'b0);
        chk("w1_rst_zero", w1_zero, 1'b1);
        @(posedge clk_in);
        #2;

        // reference pins
        chk("pin_add", ref_op(64'h0000FFFF, 64'h1, 1'b0, 1'b0, 32), {1'b0, 64'h00010000});
        chk("pin_sub", ref_op(64'h5, 64'h7, 1'b1, 1'b1, 32), {1'b0, 64'hFFFFFFFD});

        // directed cases
        send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, t);
        recv(0, 1'b0, 1'b1, 32'h00010000, 1'b0);
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, t);
        recv(2, 1'b0, 1'b1, 32'h00000000, 1'b1);
        send(32'h00000005, 32'h00000007, 1'b0, 1'b1, t);
        recv(0, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0);
        send(32'h00000005, 32'h00000007, 1'b1, 1'b1, t);
        recv(1, 1'b0, 1'b1, 32'hFFFFFFFD, 1'b0);

        // back-pressure with a new request waiting during DONE
        send(32'h12345678, 32'h11111111, 1'b0, 1'b0, t);
        begin
            int k = 0;
            do begin
                @(negedge clk_in);
                k++;
            end while (!rsp_valid_out && k < 50);
            chk("bp_latency", 65'(k - 1), 65'(WORDS));
            #1;
            req_valid_in = 1'b1;
            a_in = 32'h80000000; b_in = 32'h00000001; c_in = 1'b0; sub_in = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk_in);
                chk("bp_sum", sum_out, 32'h23456789);
                chk("bp_carry", carry_out, 1'b0);
                chk("bp_valid", rsp_valid_out, 1'b1);
                chk("bp_ready", req_ready_out, 1'b0);
            end
            #1 rsp_ready_in = 1'b1;
            @(posedge clk_in);
            #2 rsp_ready_in = 1'b0;
        end
        send(32'h80000000, 32'h00000001, 1'b0, 1'b1, t);
        chk("accept_after_hs", 65'(t), 65'd1);
        recv(0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1);

        // reset in the first RUN cycle
        send(32'hDEADBEEF, 32'h01010101, 1'b1, 1'b0, t);
        reset_in = 1'b1;
        @(posedge clk_in);
        #2 reset_in = 1'b0;
        @(negedge clk_in);
        chk("mid_rst_ready", req_ready_out, 1'b1);
        chk("mid_rst_valid", rsp_valid_out, 1'b0);
        chk("mid_rst_sum", sum_out, '0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            chk("mid_rst_no_rsp", rsp_valid_out, 1'b0);
        end
        @(posedge clk_in);
        #2;

        // single-chunk instance
        chk("pin_w1", ref_op(64'hFFFF, 64'h1, 1'b0, 1'b0, 16), {1'b1, 64'h0});
        op1(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op1(16'h0003, 16'h0003, 1'b0, 1'b1);
        op1(16'h0000, 16'h0001, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            op1(BITS'($urandom), BITS'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // randomized traffic on the main instance
        for (int i = 0; i < 120; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom_range(0, 1));
            rs  = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 7));
            if (sel == 0) begin
                rb = ra; rs = 1'b1; rc = 1'b0;
            end else if (sel == 1) begin
                rb = ~ra; rs = 1'b0; rc = 1'b1;
            end else if (sel == 2) begin
                ra = '1;
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_in);
                #2;
            end
            send(ra, rb, rc, rs, t);
            recv(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
        end

        @(negedge clk_in);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
